// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : receiver state encoding and baud divisor helper.
// Revision : 1.0
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4,
      DONE   = 3'd5
   } rx_state_t;

   function automatic int clk_divide(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// uart_sync2 : two-flop synchronizer; both flops reset to the line idle level.
// Revision   : 1.0
// ============================================================================
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 UART receiver, mid-bit sampling; optional even parity bit
//           enabled by macro UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 19200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] rx_data_out,
   output logic                  rx_active,
   output logic                  done_rx,
   output logic                  frame_err,
   output logic                  parity_err
);

   localparam int CLK_DIVIDE = clk_divide(CLK_FREQ, BAUD_RATE);
   localparam int HALF       = CLK_DIVIDE / 2;
   localparam int CNT_W      = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;
   localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIVIDE - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   rx_state_t             state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic                  done_nxt;
   logic                  frame_err_nxt;
   logic                  rx_s;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

`ifdef UART_RX_PARITY_EN
   logic par_bit, par_bit_nxt;
   logic parity_err_nxt;
   logic par_ok;

   // Even parity: data bits plus parity bit carry an even number of ones.
   assign par_ok = ~(^{shreg, par_bit});
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shreg       <= '0;
         rx_data_out <= '0;
         done_rx     <= 1'b0;
         frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit     <= 1'b0;
         parity_err  <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         shreg       <= shreg_nxt;
         rx_data_out <= data_nxt;
         done_rx     <= done_nxt;
         frame_err   <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
         par_bit     <= par_bit_nxt;
         parity_err  <= parity_err_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idx_nxt       = idx;
      shreg_nxt     = shreg;
      data_nxt      = rx_data_out;
      done_nxt      = 1'b0;
      frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_nxt    = par_bit;
      parity_err_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // Re-check the line at mid start bit to reject glitches.
            if (cnt == HALF_LAST) begin
               cnt_nxt   = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == DIV_LAST) begin
               cnt_nxt        = '0;
               shreg_nxt[idx] = rx_s;
               if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == DIV_LAST) begin
               cnt_nxt     = '0;
               par_bit_nxt = rx_s;
               state_nxt   = STOP;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`endif
         STOP: begin
            if (cnt == DIV_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  state_nxt = DONE;
               end else begin
                  frame_err_nxt = 1'b1;
                  state_nxt     = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DONE: begin
`ifdef UART_RX_PARITY_EN
            if (par_ok) begin
               done_nxt = 1'b1;
               data_nxt = shreg;
            end else begin
               parity_err_nxt = 1'b1;
            end
`else
            done_nxt = 1'b1;
            data_nxt = shreg;
`endif
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   assign rx_active = (state == DATA);

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : scoreboard bench for uart_rx at a scaled-down bit period.
// Revision   : 1.0
// ============================================================================
module tb_uart_rx;

   localparam int DATA_WIDTH = 8;
   localparam int CLK_FREQ   = 50000000;
   localparam int BAUD_RATE  = 192000;
   localparam int CLK_DIVIDE = CLK_FREQ / BAUD_RATE;
   localparam int GLITCH     = 50;

   localparam int EV_NONE = 0;
   localparam int EV_DONE = 1;
   localparam int EV_FERR = 2;
   localparam int EV_PERR = 3;

   typedef struct {
      int                    kind;
      logic [DATA_WIDTH-1:0] data;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  rx;
   logic [DATA_WIDTH-1:0] rx_data_out;
   logic                  rx_active;
   logic                  done_rx;
   logic                  frame_err;
   logic                  parity_err;

   int   checks   = 0;
   int   failures = 0;
   int   active_cycles = 0;
   int   collisions    = 0;
   int   doubles       = 0;
   logic prev_done     = 1'b0;
   exp_t exp_q[$];

   uart_rx #(
      .DATA_WIDTH (DATA_WIDTH),
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .rx_data_out (rx_data_out),
      .rx_active   (rx_active),
      .done_rx     (done_rx),
      .frame_err   (frame_err),
      .parity_err  (parity_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_evt(input int kind, input logic [DATA_WIDTH-1:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic take_evt(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_evt", kind, EV_NONE);
      end else begin
         e = exp_q.pop_front();
         check("evt_kind", kind, e.kind);
         if (kind == EV_DONE) check("evt_data", {24'd0, rx_data_out}, {24'd0, e.data});
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_active) active_cycles++;
         if (done_rx && frame_err) collisions++;
         if (done_rx && prev_done) doubles++;
         if (done_rx)    take_evt(EV_DONE);
         if (frame_err)  take_evt(EV_FERR);
         if (parity_err) take_evt(EV_PERR);
      end
      prev_done = done_rx;
   end

   task automatic send_bit(input logic b, input int cycles);
      rx = b;
      repeat (cycles) @(posedge clk);
   endtask

   task automatic idle_bits(input int n);
      send_bit(1'b1, n * CLK_DIVIDE);
   endtask

   task automatic send_frame(input logic [DATA_WIDTH-1:0] d, input bit stop_ok, input bit par_ok);
      send_bit(1'b0, CLK_DIVIDE);
      for (int i = 0; i < DATA_WIDTH; i++) send_bit(d[i], CLK_DIVIDE);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ !par_ok, CLK_DIVIDE);
`endif
      // A bad stop bit recovers before the receiver's next mid-bit look.
      if (stop_ok) send_bit(1'b1, CLK_DIVIDE);
      else         send_bit(1'b0, (CLK_DIVIDE * 3) / 4);
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_data",   {24'd0, rx_data_out}, 32'd0);
      check("rst_active", {31'd0, rx_active},   32'd0);
      check("rst_done",   {31'd0, done_rx},     32'd0);
      check("rst_ferr",   {31'd0, frame_err},   32'd0);
      check("rst_perr",   {31'd0, parity_err},  32'd0);
      @(posedge clk);
      rst = 1'b0;
      idle_bits(3);

      active_cycles = 0;
      expect_evt(EV_DONE, 8'hA5);
      send_frame(8'hA5, 1'b1, 1'b1);
      idle_bits(2);
      check("a5_active_cycles", active_cycles, DATA_WIDTH * CLK_DIVIDE);
      check("a5_held", {24'd0, rx_data_out}, 32'h0000_00A5);

      active_cycles = 0;
      send_bit(1'b0, GLITCH);
      idle_bits(4);
      check("glitch_active", active_cycles, 32'd0);

      expect_evt(EV_FERR, 8'h00);
      send_frame(8'h3C, 1'b0, 1'b1);
      idle_bits(3);
      check("ferr_data_kept", {24'd0, rx_data_out}, 32'h0000_00A5);

      expect_evt(EV_DONE, 8'h01);
      expect_evt(EV_DONE, 8'hFF);
      send_frame(8'h01, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      idle_bits(2);

      send_bit(1'b0, CLK_DIVIDE);
      for (int i = 0; i < 4; i++) send_bit(i[0], CLK_DIVIDE);
      send_bit(1'b1, CLK_DIVIDE / 2);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_data", {24'd0, rx_data_out}, 32'd0);
      check("midrst_active", {31'd0, rx_active}, 32'd0);
      idle_bits(3);
      expect_evt(EV_DONE, 8'h99);
      send_frame(8'h99, 1'b1, 1'b1);
      idle_bits(2);
      check("post_rst_held", {24'd0, rx_data_out}, 32'h0000_0099);

`ifdef UART_RX_PARITY_EN
      expect_evt(EV_PERR, 8'h00);
      send_frame(8'h07, 1'b1, 1'b0);
      idle_bits(2);
      check("perr_data_kept", {24'd0, rx_data_out}, 32'h0000_0099);
      expect_evt(EV_DONE, 8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      idle_bits(2);
`endif

      idle_bits(2);
      check("pending_events", exp_q.size(), 32'd0);
      check("done_ferr_same_cycle", collisions, 32'd0);
      check("done_wide_pulse", doubles, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
